sram_ctrl: RTL and testbench

//   Initiator side of the sram port: turns one-at-a-time load/store requests from the

---
 rtl/sram_ctrl.sv | 143 ++++++++++++++
 tb/tb_sram_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Single-outstanding load/store front end for the sram port; partial stores become read-modify-write.
// Optional feature macro: SRAM_CTRL_ALIGN_CHECK_EN adds rsp_err and rejects unaligned/out-of-range requests.
module sram_ctrl #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 10240
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [AWIDTH-1:0]      req_addr,
   input  logic [DWIDTH-1:0]      req_wdata,
   input  logic [DWIDTH/8-1:0]    req_be,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DWIDTH-1:0]      rsp_rdata,
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
   output logic                   rsp_err,
`endif
   output logic [AWIDTH-1:0]      mem_addr,
   output logic [DWIDTH-1:0]      mem_din,
   output logic                   mem_cs,
   output logic                   mem_rd,
   output logic                   mem_wr,
   input  logic [DWIDTH-1:0]      mem_dout
);

   localparam int BW = DWIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [AWIDTH-1:2]   r_addr;
   logic [DWIDTH-1:0]   r_wdata;
   logic [DWIDTH-1:0]   r_merged;
   logic [DWIDTH-1:0]   r_rdata;
   logic [BW-1:0]       r_be;
   logic [DWIDTH-1:0]   w_merged;
   logic                w_accept;
   logic                w_err;
   logic                w_mem_active;
   logic                w_unused;

   assign w_accept = req_valid && req_ready;
   assign w_unused = &{1'b0, req_addr[1:0], (DEPTH > 0)};

`ifdef SRAM_CTRL_ALIGN_CHECK_EN
   logic r_err;
   assign w_err   = (req_addr[1:0] != 2'b00) ||
                    ({2'b00, req_addr[AWIDTH-1:2]} >= AWIDTH'(DEPTH));
   assign rsp_err = r_err;
`else
   assign w_err = 1'b0;
`endif

   // Lane-wise merge of store data over the word currently being read back.
   generate
      for (genvar gi = 0; gi < BW; gi++) begin : g_merge
         assign w_merged[8*gi +: 8] = r_be[gi] ? r_wdata[8*gi +: 8] : mem_dout[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      req_ready    = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_err)
                  w_state_next = S_RESP;
               else if (!req_we)
                  w_state_next = S_READ;
               else if (&req_be)
                  w_state_next = S_WRITE;
               else if (req_be == '0)
                  w_state_next = S_RESP;
               else
                  w_state_next = S_RMW_RD;
            end
         end
         S_READ:   w_state_next = S_RESP;
         S_WRITE:  w_state_next = S_RESP;
         S_RMW_RD: w_state_next = S_RMW_WR;
         S_RMW_WR: w_state_next = S_RESP;
         S_RESP:   if (rsp_ready) w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // Strobes come from the state register alone; cs is also killed by reset
   // so an interrupted write never lands in the sram.
   assign mem_rd       = (r_state == S_READ) || (r_state == S_RMW_RD);
   assign mem_wr       = (r_state == S_WRITE) || (r_state == S_RMW_WR);
   assign w_mem_active = mem_rd || mem_wr;
   assign mem_cs       = w_mem_active && !rst;
   assign mem_addr     = {r_addr, 2'b00};
   assign mem_din      = (r_state == S_WRITE)  ? r_wdata  :
                         (r_state == S_RMW_WR) ? r_merged : '0;
   assign rsp_valid    = (r_state == S_RESP);
   assign rsp_rdata    = r_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_be     <= '0;
         r_merged <= '0;
         r_rdata  <= '0;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
         r_err    <= 1'b0;
`endif
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_addr  <= req_addr[AWIDTH-1:2];
            r_wdata <= req_wdata;
            r_be    <= req_be;
            if (req_we || w_err)
               r_rdata <= '0;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
            r_err <= w_err;
`endif
         end
         if (r_state == S_READ)
            r_rdata <= mem_dout;
         if (r_state == S_RMW_RD)
            r_merged <= w_merged;
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Table-driven bench for sram_ctrl with a behavioural sram model and an rdata scoreboard queue.
module tb_sram_ctrl;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int BW    = 4;
   localparam int DEPTH = 10240;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [BW-1:0] req_be;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
   logic          rsp_err;
`endif
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          mem_cs;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_dout;

   sram_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
      .rsp_err   (rsp_err),
`endif
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_cs    (mem_cs),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_dout  (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural sram: combinational read while cs&&rd, write at the rising edge.
   logic [DW-1:0] mem [0:1023];
   int            wr_commits = 0;
   logic          both_seen  = 1'b0;

   assign mem_dout = (mem_cs && mem_rd) ? mem[mem_addr[11:2]] : '0;

   always @(posedge clk) begin
      if (mem_cs && mem_wr) begin
         mem[mem_addr[11:2]] <= mem_din;
         wr_commits <= wr_commits + 1;
      end
   end

   always @(negedge clk) begin
      if (mem_rd && mem_wr) both_seen <= 1'b1;
   end

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
      logic [DW-1:0] exp_rdata;
      int            exp_lat;
      int            exp_cs;
      int            exp_wr;
      logic          exp_err;
      int            hold;
   } vec_t;

   vec_t          vecs[$];
   logic [DW-1:0] sb_q[$];
   int            checks = 0;
   int            errors = 0;

   function automatic vec_t mk(input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                               input logic [DW-1:0] exp_rdata, input int lat,
                               input int ncs, input int nwr, input logic err,
                               input int hold);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
      v.exp_rdata = exp_rdata; v.exp_lat = lat; v.exp_cs = ncs; v.exp_wr = nwr;
      v.exp_err = err; v.hold = hold;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_txn(input vec_t v, input int idx);
      int            lat;
      int            ncs;
      int            nwr;
      logic          got;
      logic [DW-1:0] exp_rd;
      logic [DW-1:0] held;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_be    = v.be;
      check($sformatf("t%0d req_ready_idle", idx), 32'(req_ready), 32'd1);
      @(posedge clk);
      sb_q.push_back(v.exp_rdata);
      lat = 0; ncs = 0; nwr = 0; got = 1'b0;
      while (lat < 10 && !got) begin
         @(negedge clk);
         req_valid = 1'b0;
         lat++;
         if (rsp_valid) got = 1'b1;
         else begin
            ncs += int'(mem_cs);
            nwr += int'(mem_wr);
         end
      end
      check($sformatf("t%0d latency", idx), 32'(lat), 32'(v.exp_lat));
      check($sformatf("t%0d cs_cycles", idx), 32'(ncs), 32'(v.exp_cs));
      check($sformatf("t%0d wr_cycles", idx), 32'(nwr), 32'(v.exp_wr));
      exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      check($sformatf("t%0d rsp_rdata", idx), rsp_rdata, exp_rd);
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
      check($sformatf("t%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
`endif
      held = rsp_rdata;
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("t%0d hold%0d rsp_valid", idx, h), 32'(rsp_valid), 32'd1);
         check($sformatf("t%0d hold%0d rsp_rdata", idx, h), rsp_rdata, held);
         check($sformatf("t%0d hold%0d req_ready", idx, h), 32'(req_ready), 32'd0);
         check($sformatf("t%0d hold%0d mem_cs", idx, h), 32'(mem_cs), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check($sformatf("t%0d rsp_valid_after", idx), 32'(rsp_valid), 32'd0);
      check($sformatf("t%0d req_ready_after", idx), 32'(req_ready), 32'd1);
      $display("txn %0d we=%0d addr=0x%08h wdata=0x%08h be=%b -> rdata=0x%08h lat=%0d cs=%0d wr=%0d",
               idx, v.we, v.addr, v.wdata, v.be, held, lat, ncs, nwr);
   endtask

   initial begin
      int c0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[32'h20 >> 2] = 32'h11223344;
      mem[32'h24 >> 2] = 32'h24242424;
      mem[32'h30 >> 2] = 32'h55555555;
      mem[32'h40 >> 2] = 32'hA5A5A5A5;
      mem[32'h50 >> 2] = 32'h0BADF00D;

      //             we    addr          wdata          be       exp_rdata      lat cs wr err hold
      vecs.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0,        2, 1, 1, 1'b0, 0));
      vecs.push_back(mk(1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 2, 1, 0, 1'b0, 0));
      vecs.push_back(mk(1'b1, 32'h20, 32'h000000AA, 4'b0001, 32'h0,        3, 2, 1, 1'b0, 0));
      vecs.push_back(mk(1'b0, 32'h20, 32'h0,        4'b0000, 32'h112233AA, 2, 1, 0, 1'b0, 5));
      vecs.push_back(mk(1'b1, 32'h40, 32'h11223344, 4'b0110, 32'h0,        3, 2, 1, 1'b0, 0));
      vecs.push_back(mk(1'b0, 32'h40, 32'h0,        4'b0000, 32'hA52233A5, 2, 1, 0, 1'b0, 0));
      vecs.push_back(mk(1'b1, 32'h50, 32'hFFFFFFFF, 4'b0000, 32'h0,        1, 0, 0, 1'b0, 0));
      vecs.push_back(mk(1'b0, 32'h50, 32'h0,        4'b0000, 32'h0BADF00D, 2, 1, 0, 1'b0, 0));
`ifdef SRAM_CTRL_ALIGN_CHECK_EN
      vecs.push_back(mk(1'b0, 32'h22,      32'h0,   4'b0000, 32'h0,        1, 0, 0, 1'b1, 0));
      vecs.push_back(mk(1'b0, 32'(4*DEPTH), 32'h0,  4'b0000, 32'h0,        1, 0, 0, 1'b1, 0));
      vecs.push_back(mk(1'b0, 32'h24,      32'h0,   4'b0000, 32'h24242424, 2, 1, 0, 1'b0, 0));
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst mem_cs_gated", 32'(mem_cs), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rsp_rdata", rsp_rdata, 32'd0);
      check("rst mem_cs", 32'(mem_cs), 32'd0);
      check("rst mem_rd", 32'(mem_rd), 32'd0);
      check("rst mem_wr", 32'(mem_wr), 32'd0);
      check("rst mem_addr", mem_addr, 32'd0);
      check("rst mem_din", mem_din, 32'd0);
      check("rst req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) do_txn(vecs[i], i);

      // Reset lands while the partial store is in its read phase.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
      req_wdata = 32'hFFFFFFFF; req_be = 4'b0010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rmwrst in_rmw_rd cs", 32'(mem_cs), 32'd1);
      check("rmwrst in_rmw_rd rd", 32'(mem_rd), 32'd1);
      c0 = wr_commits;
      rst = 1'b1;
      #1;
      check("rmwrst cs_gated", 32'(mem_cs), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rmwrst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rmwrst req_ready", 32'(req_ready), 32'd1);
      check("rmwrst mem_wr", 32'(mem_wr), 32'd0);
      repeat (2) @(negedge clk);
      check("rmwrst no_commit", 32'(wr_commits), 32'(c0));
      check("rmwrst word", mem[32'h30 >> 2], 32'h55555555);
      $display("txn rmw-reset addr=0x00000030 be=0010 word=0x%08h", mem[32'h30 >> 2]);
      do_txn(mk(1'b0, 32'h30, 32'h0, 4'b0000, 32'h55555555, 2, 1, 0, 1'b0, 0), 100);

      check("rd_wr_exclusive", 32'(both_seen), 32'd0);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
